// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 word-stream controller.
package aes_pkg;
   localparam int AES_BLOCK_W      = 128;
   localparam int AES_CORE_LATENCY = 13;

   typedef enum logic [2:0] {LOAD, KICK, START, WAIT, DRAIN} strm_state_t;
endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Valid/ready word streams between the bus/DMA side and the AES stream controller.
interface aes_stream_ctrl_if #(parameter int WORD_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_last;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_last);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/aes_word_packer.sv
// Assembles WORD_W-bit words into one 128-bit block; word index 0 lands in the top bits.
module aes_word_packer
   import aes_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_wr_en,
   input  logic [$clog2(AES_BLOCK_W/WORD_W)-1:0]      i_idx,
   input  logic [WORD_W-1:0]                          i_word,
   output logic [AES_BLOCK_W-1:0]                     o_block
);
   localparam int NWORDS = AES_BLOCK_W / WORD_W;
   localparam int PTR_W  = $clog2(NWORDS);

   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [WORD_W-1:0] r_word;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_word <= '0;
         end else if (i_wr_en && (i_idx == PTR_W'(gi))) begin
            r_word <= i_word;
         end
      end

      assign o_block[AES_BLOCK_W-1-gi*WORD_W -: WORD_W] = r_word;
   end
endmodule

// File: rtl/aes_stream_ctrl.sv
// Word-stream front/back end for an external iterative AES-128 core: load block, kick core, wait, drain.
module aes_stream_ctrl
   import aes_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int WAIT_LIMIT = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AES_BLOCK_W-1:0] key_in,
   aes_stream_ctrl_if.slave       strm,
   output logic                   core_reset,
   output logic                   core_start,
   output logic [AES_BLOCK_W-1:0] core_key,
   output logic [AES_BLOCK_W-1:0] core_plaintext,
   input  logic                   core_done,
   input  logic [AES_BLOCK_W-1:0] core_ciphertext,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [31:0]            blk_count
);
   localparam int NWORDS = AES_BLOCK_W / WORD_W;
   localparam int PTR_W  = $clog2(NWORDS);
   localparam int WC_W   = $clog2(WAIT_LIMIT + 1);

   strm_state_t            r_state, w_state_next;
   logic [PTR_W-1:0]       r_ptr, w_ptr_inc;
   logic [WC_W-1:0]        r_wait_cnt;
   logic                   r_in_ready, r_busy, r_out_valid, r_out_last, r_core_reset, r_core_start;
   logic [WORD_W-1:0]      r_out_data;
   logic [AES_BLOCK_W-1:0] r_core_key, r_core_pt, r_cipher;
   logic                   r_timeout_err;
   logic [31:0]            r_blk_count;

   logic                   w_in_hs, w_out_hs, w_ptr_last, w_wait_expired;
   logic                   w_in_ready_next, w_busy_next, w_out_valid_next, w_out_last_next;
   logic                   w_core_reset_next, w_core_start_next;
   logic [WORD_W-1:0]      w_out_data_next;
   logic [AES_BLOCK_W-1:0] w_plain_block;
   logic [WORD_W-1:0]      w_cipher_words [NWORDS];

   assign w_in_hs        = strm.in_valid & r_in_ready;
   assign w_out_hs       = r_out_valid & strm.out_ready;
   assign w_ptr_last     = (r_ptr == PTR_W'(NWORDS - 1));
   assign w_ptr_inc      = r_ptr + PTR_W'(1);
   assign w_wait_expired = (r_wait_cnt == WC_W'(WAIT_LIMIT - 1));

   aes_word_packer #(.WORD_W(WORD_W)) u_packer (
      .clk     (clk),
      .rst     (reset),
      .i_wr_en (w_in_hs),
      .i_idx   (r_ptr),
      .i_word  (strm.in_data),
      .o_block (w_plain_block)
   );

   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_cipher_word
      assign w_cipher_words[gi] = r_cipher[AES_BLOCK_W-1-gi*WORD_W -: WORD_W];
   end

   always_comb begin : next_state
      w_state_next = r_state;
      case (r_state)
         LOAD:    if (w_in_hs && w_ptr_last) w_state_next = KICK;
         KICK:    w_state_next = START;
         START:   w_state_next = WAIT;
         WAIT: begin
            if (core_done)           w_state_next = DRAIN;
            else if (w_wait_expired) w_state_next = LOAD;
         end
         DRAIN:   if (w_out_hs && w_ptr_last) w_state_next = LOAD;
         default: w_state_next = LOAD;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with the state itself.
   always_comb begin : next_outputs
      w_in_ready_next   = (w_state_next == LOAD);
      w_busy_next       = (w_state_next != LOAD);
      w_out_valid_next  = (w_state_next == DRAIN);
      w_core_start_next = (w_state_next == START);
      w_core_reset_next = (w_state_next == KICK) ||
                          (r_state == LOAD && w_state_next == LOAD && r_core_reset);
      w_out_data_next   = r_out_data;
      w_out_last_next   = r_out_last;
      if (r_state == WAIT && w_state_next == DRAIN) begin
         w_out_data_next = core_ciphertext[AES_BLOCK_W-1 -: WORD_W];
         w_out_last_next = 1'b0;
      end else if (r_state == DRAIN && w_out_hs) begin
         if (w_ptr_last) begin
            w_out_last_next = 1'b0;
         end else begin
            w_out_data_next = w_cipher_words[w_ptr_inc];
            w_out_last_next = (w_ptr_inc == PTR_W'(NWORDS - 1));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin : state_reg
      if (reset) begin
         r_state      <= LOAD;
         r_in_ready   <= 1'b1;
         r_busy       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= '0;
         r_core_reset <= 1'b1;
         r_core_start <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_in_ready   <= w_in_ready_next;
         r_busy       <= w_busy_next;
         r_out_valid  <= w_out_valid_next;
         r_out_last   <= w_out_last_next;
         r_out_data   <= w_out_data_next;
         r_core_reset <= w_core_reset_next;
         r_core_start <= w_core_start_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin : datapath
      if (reset) begin
         r_ptr         <= '0;
         r_wait_cnt    <= '0;
         r_core_key    <= '0;
         r_core_pt     <= '0;
         r_cipher      <= '0;
         r_timeout_err <= 1'b0;
         r_blk_count   <= '0;
      end else begin
         if ((r_state == LOAD && w_in_hs) || (r_state == DRAIN && w_out_hs)) begin
            r_ptr <= w_ptr_last ? '0 : w_ptr_inc;
         end
         if (r_state == START)     r_wait_cnt <= '0;
         else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + WC_W'(1);
         if (r_state == KICK) begin
            r_core_key <= key_in;
            r_core_pt  <= w_plain_block;
         end
         if (r_state == WAIT && core_done) r_cipher <= core_ciphertext;
         if (r_state == WAIT && !core_done && w_wait_expired) r_timeout_err <= 1'b1;
         if (r_state == DRAIN && w_out_hs && w_ptr_last) r_blk_count <= r_blk_count + 32'd1;
      end
   end

   assign strm.in_ready   = r_in_ready;
   assign strm.out_valid  = r_out_valid;
   assign strm.out_data   = r_out_data;
   assign strm.out_last   = r_out_last;
   assign core_reset      = r_core_reset;
   assign core_start      = r_core_start;
   assign core_key        = r_core_key;
   assign core_plaintext  = r_core_pt;
   assign busy            = r_busy;
   assign timeout_err     = r_timeout_err;
   assign blk_count       = r_blk_count;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a behavioural 13-cycle core stub.
module tb_aes_stream_ctrl;
   import aes_pkg::*;

   localparam int W          = 32;
   localparam int NW         = AES_BLOCK_W / W;
   localparam int WAIT_LIMIT = 31;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] key_in, core_key, core_plaintext, core_ciphertext;
   logic         core_reset, core_start, busy, timeout_err;
   logic         core_done = 1'b0;
   logic [31:0]  blk_count;

   always #5 clk = ~clk;

   aes_stream_ctrl_if #(.WORD_W(W)) s_if ();

   aes_stream_ctrl #(.WORD_W(W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk             (clk),
      .reset           (reset),
      .key_in          (key_in),
      .strm            (s_if),
      .core_reset      (core_reset),
      .core_start      (core_start),
      .core_key        (core_key),
      .core_plaintext  (core_plaintext),
      .core_done       (core_done),
      .core_ciphertext (core_ciphertext),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .blk_count       (blk_count)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_blk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Core stub: returns the FIPS-197 answer for the FIPS vector, otherwise ~pt ^ key.
   function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      return ~pt ^ key;
   endfunction

   logic         core_never = 1'b0;
   logic         core_active = 1'b0;
   int           core_cnt = 0;
   logic [127:0] core_ct_r = '0;

   always @(posedge clk) begin
      if (core_reset) begin
         core_done   <= 1'b0;
         core_active <= 1'b0;
         core_cnt    <= 0;
      end else if (core_start) begin
         core_active <= 1'b1;
         core_cnt    <= 1;
         core_ct_r   <= core_fn(core_plaintext, core_key);
      end else if (core_active && !core_done && !core_never) begin
         core_cnt <= core_cnt + 1;
         if (core_cnt == AES_CORE_LATENCY - 1) core_done <= 1'b1;
      end
   end
   assign core_ciphertext = core_done ? core_ct_r : '0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Back-to-back monitor: every start needs a preceding core_reset; no input acceptance while busy.
   bit mon_en = 1'b0;
   bit seen_rst = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (core_reset) seen_rst = 1'b1;
         if (core_start) begin
            chk("b2b reset_before_start", seen_rst, 1'b1);
            seen_rst = 1'b0;
         end
         if (s_if.out_valid || core_start) chk("b2b in_ready_low", s_if.in_ready, 1'b0);
      end
   end

   task automatic send_word(input logic [W-1:0] w);
      int n = 0;
      s_if.in_valid = 1'b1;
      s_if.in_data  = w;
      while (s_if.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL in_ready timeout: got 0 expected 1");
      end
      @(negedge clk);
   endtask

   task automatic send_block(input logic [127:0] pt, input bit keep_valid);
      for (int i = 0; i < NW; i++) send_word(pt[AES_BLOCK_W-1-W*i -: W]);
      if (!keep_valid) s_if.in_valid = 1'b0;
      $display("sent block %h", pt);
   endtask

   task automatic recv_block(input logic [127:0] exp_ct, input int stall, input int count,
                             input string tag);
      for (int i = 0; i < count; i++) begin
         int n = 0;
         logic [W-1:0] hold, exp_w;
         exp_w = exp_ct[AES_BLOCK_W-1-W*i -: W];
         s_if.out_ready = (stall == 0);
         while (s_if.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s out_valid timeout word %0d: got 0 expected 1", tag, i);
         end
         hold = s_if.out_data;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " hold_data"}, s_if.out_data, hold);
            chk({tag, " hold_valid"}, s_if.out_valid, 1'b1);
         end
         chk({tag, " out_data"}, s_if.out_data, exp_w);
         chk({tag, " out_last"}, s_if.out_last, (i == NW - 1));
         $display("%s word %0d data=%h last=%0b", tag, i, s_if.out_data, s_if.out_last);
         s_if.out_ready = 1'b1;
         @(negedge clk);
      end
      s_if.out_ready = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] ct, input int stall, input string tag);
      key_in = key;
      send_block(pt, 1'b0);
      recv_block(ct, stall, NW, tag);
      exp_blk = exp_blk + 32'd1;
      chk({tag, " blk_count"}, blk_count, exp_blk);
      chk({tag, " valid_clear"}, s_if.out_valid, 1'b0);
      chk({tag, " in_ready_back"}, s_if.in_ready, 1'b1);
   endtask

   task automatic wait_start(output int t);
      int n = 0;
      while (core_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL core_start timeout: got 0 expected 1");
      end
      t = cyc;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      s_if.in_valid  = 1'b0;
      s_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_blk = '0;
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           stall;
      string        name;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  t0, n;
      bit  saw_valid;

      vecs[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, "kat"};
      vecs[1] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 5, "backpressure"};
      vecs[2] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'hdeadbeef0123456789abcdefcafef00d,
                  '0, 0, "vec2"};
      vecs[3] = '{128'hffffffff00000000a5a5a5a55a5a5a5a, 128'h13579bdf2468ace0fedcba9876543210,
                  '0, 2, "vec3"};
      for (int i = 2; i < 4; i++) vecs[i].ct = ~vecs[i].pt ^ vecs[i].key;

      reset = 1'b1;
      key_in = '0;
      s_if.in_valid = 1'b0;
      s_if.in_data = '0;
      s_if.out_ready = 1'b0;
      exp_blk = '0;
      repeat (3) @(negedge clk);

      chk("rst in_ready", s_if.in_ready, 1'b1);
      chk("rst out_valid", s_if.out_valid, 1'b0);
      chk("rst out_last", s_if.out_last, 1'b0);
      chk("rst out_data", s_if.out_data, '0);
      chk("rst core_reset", core_reset, 1'b1);
      chk("rst core_start", core_start, 1'b0);
      chk("rst core_key", core_key, '0);
      chk("rst core_plaintext", core_plaintext, '0);
      chk("rst busy", busy, 1'b0);
      chk("rst timeout_err", timeout_err, 1'b0);
      chk("rst blk_count", blk_count, '0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("first load core_reset", core_reset, 1'b1);

      // Known answer with latency and KICK-cycle checks.
      key_in = FIPS_KEY;
      send_block(FIPS_PT, 1'b0);
      chk("kick busy", busy, 1'b1);
      chk("kick in_ready", s_if.in_ready, 1'b0);
      chk("kick core_reset", core_reset, 1'b1);
      wait_start(t0);
      chk("start core_reset", core_reset, 1'b0);
      chk("latched key", core_key, FIPS_KEY);
      chk("latched plaintext", core_plaintext, FIPS_PT);
      n = 0;
      while (s_if.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("start_to_out_valid cycles", 128'(cyc - t0), 128'd14);
      recv_block(FIPS_CT, 0, NW, "kat0");
      exp_blk = exp_blk + 32'd1;
      chk("kat0 blk_count", blk_count, exp_blk);
      chk("kat0 core_reset low in load", core_reset, 1'b0);

      for (int v = 0; v < 4; v++)
         run_block(vecs[v].key, vecs[v].pt, vecs[v].ct, vecs[v].stall, vecs[v].name);

      // Timeout: the core never finishes.
      core_never = 1'b1;
      key_in = FIPS_KEY;
      send_block(vecs[2].pt, 1'b0);
      wait_start(t0);
      saw_valid = 1'b0;
      repeat (WAIT_LIMIT) begin
         @(negedge clk);
         if (s_if.out_valid) saw_valid = 1'b1;
      end
      chk("timeout early err", timeout_err, 1'b0);
      chk("timeout early in_ready", s_if.in_ready, 1'b0);
      @(negedge clk);
      chk("timeout err", timeout_err, 1'b1);
      chk("timeout in_ready", s_if.in_ready, 1'b1);
      chk("timeout busy", busy, 1'b0);
      chk("timeout no out_valid", saw_valid | s_if.out_valid, 1'b0);
      chk("timeout blk_count", blk_count, exp_blk);
      core_never = 1'b0;
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, "after_timeout");
      chk("timeout sticky", timeout_err, 1'b1);

      // Reset in the middle of draining.
      key_in = FIPS_KEY;
      send_block(FIPS_PT, 1'b0);
      recv_block(FIPS_CT, 0, 2, "partial");
      #2 reset = 1'b1;
      #1;
      chk("midrst out_valid", s_if.out_valid, 1'b0);
      chk("midrst core_reset", core_reset, 1'b1);
      chk("midrst timeout_err", timeout_err, 1'b0);
      chk("midrst blk_count", blk_count, '0);
      @(negedge clk);
      reset = 1'b0;
      exp_blk = '0;
      repeat (3) @(negedge clk);
      chk("midrst no replay", s_if.out_valid, 1'b0);
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, "post_reset");

      // Back-to-back blocks with in_valid held high.
      apply_reset();
      key_in = FIPS_KEY;
      seen_rst = 1'b0;
      mon_en = 1'b1;
      fork
         begin
            send_block(FIPS_PT, 1'b1);
            send_block(vecs[2].pt, 1'b1);
            send_block(vecs[3].pt, 1'b1);
            s_if.in_valid = 1'b0;
         end
         begin
            recv_block(FIPS_CT, 0, NW, "b2b0");
            recv_block(core_fn(vecs[2].pt, FIPS_KEY), 0, NW, "b2b1");
            recv_block(core_fn(vecs[3].pt, FIPS_KEY), 0, NW, "b2b2");
         end
      join
      mon_en = 1'b0;
      chk("b2b blk_count", blk_count, 32'd3);
      exp_blk = 32'd3;

      // Counter wrap.
      force dut.r_blk_count = 32'hffff_ffff;
      @(negedge clk);
      release dut.r_blk_count;
      @(negedge clk);
      chk("wrap preset", blk_count, 32'hffff_ffff);
      exp_blk = 32'hffff_ffff;
      run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, "wrap");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
